// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_like_pkg : request entry type, size codes and lane-merge helper
// Revision 1.0
// ----------------------------------------------------------------------------
package sram_like_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int LAT_MAX = 7;
  // Widest word index a 32-bit byte address can carry; narrower memories zero-extend.
  localparam int IDX_W   = 30;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic [3:0]       wstrb;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
  } req_entry_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// req_fifo : in-order request FIFO with a saturating per-entry age counter
// Revision 1.0
// ----------------------------------------------------------------------------
module req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     head_ready_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int         PW      = $clog2(DEPTH);
  localparam int         CW      = PW + 1;
  localparam logic [2:0] AGE_SAT = 3'(LAT);

  logic [W-1:0]     data_q [DEPTH];
  logic [2:0]       age_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q + PW'(push_i);
    rptr_d  = rptr_q + PW'(pop_i);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (age_q[i] != AGE_SAT)) age_q[i] <= age_q[i] + 3'd1;
      end
      if (pop_i) valid_q[rptr_q] <= 1'b0;
      // The push slot is never the pop slot: pushes are refused while full.
      if (push_i) begin
        valid_q[wptr_q] <= 1'b1;
        age_q[wptr_q]   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) data_q[wptr_q] <= din_i;
  end

  assign dout_o       = data_q[rptr_q];
  assign head_ready_o = valid_q[rptr_q] && (age_q[rptr_q] == AGE_SAT);
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_sram_responder : fixed-latency in-order memory behind the SRAM-like data port
// Revision 1.0
// ----------------------------------------------------------------------------
module data_sram_responder
  import sram_like_pkg::*;
#(
  parameter int AW     = 12,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [2:0]  outstanding
);

  localparam int LAT_EFF = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
  localparam int CW      = $clog2(QDEPTH) + 1;

  logic [31:0]                  mem_q [0:(1<<AW)-1];
  req_entry_t                   req_in;
  req_entry_t                   head;
  logic [$bits(req_entry_t)-1:0] head_raw;
  logic [AW-1:0]                head_idx;
  logic                         push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]                fifo_count;
  logic                         data_ok_q;
  logic [31:0]                  rdata_q;
  logic                         unused_ok;

  always_comb begin
    req_in       = '0;
    req_in.wr    = data_sram_wr;
    req_in.size  = data_sram_size;
    req_in.wstrb = data_sram_wstrb;
    req_in.idx   = IDX_W'(data_sram_addr[AW+1:2]);
    req_in.wdata = data_sram_wdata;
  end

  assign push = data_sram_req & ~fifo_full;

  req_fifo #(
    .W     ($bits(req_entry_t)),
    .DEPTH (QDEPTH),
    .LAT   (LAT_EFF)
  ) u_req_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .din_i        (req_in),
    .pop_i        (pop),
    .dout_o       (head_raw),
    .head_ready_o (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign head     = head_raw;
  assign head_idx = head.idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (pop && head.wr) mem_q[head_idx] <= lane_merge(mem_q[head_idx], head.wdata, head.wstrb);
  end

  // A read retiring at this edge sees every older write, which retired on an earlier edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= pop;
      if (pop && !head.wr) rdata_q <= mem_q[head_idx];
    end
  end

  assign data_sram_addr_ok = ~fifo_full;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;
  assign outstanding       = 3'(fifo_count);

  assign unused_ok = ^{data_sram_addr, head, fifo_empty};

endmodule
`default_nettype wire
